// File: rtl/xvc_packet_sender_if.sv
// Bundle between the packet sender, the packet buffer's send side and the TX sink.
// Latency: none (wires only).
// Backpressure: tx_valid/tx_ready handshake toward the sink; the buffer side is pop/index driven.
//
// Ports (signals):
//   send_avail  buffer -> sender  at least one complete packet waiting
//   send_next   sender -> buffer  one-cycle pop strobe
//   send_len    buffer -> sender  length of popped packet, valid the cycle after send_next
//   send_idx    sender -> buffer  byte read index into the current packet
//   send_data   buffer -> sender  byte at send_idx, valid one cycle after send_idx changes
//   tx_data/tx_valid/tx_last  sender -> sink
//   tx_ready    sink -> sender
// Modports: master = packet sender, slave = buffer + sink side.
interface xvc_packet_sender_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int IDX_WIDTH  = 16
);
  logic                  send_avail;
  logic                  send_next;
  logic [LEN_WIDTH-1:0]  send_len;
  logic [IDX_WIDTH-1:0]  send_idx;
  logic [DATA_WIDTH-1:0] send_data;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_last;

  modport master (
    input  send_avail, send_len, send_data, tx_ready,
    output send_next, send_idx, tx_data, tx_valid, tx_last
  );

  modport slave (
    output send_avail, send_len, send_data, tx_ready,
    input  send_next, send_idx, tx_data, tx_valid, tx_last
  );
endinterface

// File: rtl/xvc_packet_sender.sv
// Drains finished packets from the packet buffer onto a byte-wide valid/ready TX stream.
// Latency: pop->len->fetch->first beat; each data beat takes at least 2 cycles (fetch + send).
// Backpressure: tx_data/tx_last held while tx_valid & !tx_ready; no new pop until the packet ends.
//
// Ports:
//   clock    rising-edge system clock
//   reset    asynchronous active-low reset; aborts any packet in flight without pkt_done
//   enable   sampled only when idle; 0 lets the current packet finish, then stays idle
//   bus      xvc_packet_sender_if.master (buffer send side + TX stream)
//   pkt_done one-cycle pulse after the final beat is accepted (or after an empty packet)
//   busy     high whenever the sender is not idle
// Optional feature: define TX_LEN_HEADER_EN to prefix each packet with two length
// beats (len[15:8], then len[7:0]); LEN_WIDTH must then be <= 16.
module xvc_packet_sender #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int IDX_WIDTH  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  xvc_packet_sender_if.master bus,
  output logic                pkt_done,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE, POP, LEN, HDR1, HDR0, FETCH, SEND, DONE
  } state_t;

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_valid_q;
  logic                  tx_last_q;
  logic                  beat_acc;
  logic                  is_last_idx;

  assign beat_acc    = tx_valid_q & bus.tx_ready;
  // SEND is only reached with len_q >= 1, so len_q - 1 never wraps here.
  assign is_last_idx = (LEN_WIDTH'(idx_q) == (len_q - LEN_WIDTH'(1)));

`ifdef TX_LEN_HEADER_EN
  logic [15:0] len16;
  assign len16 = 16'(len_q);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enable && bus.send_avail) state_nxt = POP;
      POP:   state_nxt = LEN;
`ifdef TX_LEN_HEADER_EN
      // Header beats are sent even for empty packets.
      LEN:   state_nxt = HDR1;
      HDR1:  if (beat_acc) state_nxt = HDR0;
      HDR0:  if (beat_acc) state_nxt = tx_last_q ? DONE : FETCH;
`else
      // send_len is valid this cycle; len_q only holds it from the next one.
      LEN:   state_nxt = (bus.send_len == '0) ? DONE : FETCH;
`endif
      FETCH: state_nxt = SEND;
      SEND:  if (beat_acc) state_nxt = tx_last_q ? DONE : FETCH;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat register: a beat is loaded on the first cycle of SEND/HDRx (when no beat is
  // pending) and then held untouched until the sink takes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      if (beat_acc) begin
        tx_valid_q <= 1'b0;
        tx_last_q  <= 1'b0;
      end
      case (state)
        LEN: begin
          len_q <= bus.send_len;
          idx_q <= '0;
        end
`ifdef TX_LEN_HEADER_EN
        HDR1: if (!tx_valid_q) begin
          tx_data_q  <= DATA_WIDTH'(len16[15:8]);
          tx_valid_q <= 1'b1;
          tx_last_q  <= 1'b0;
        end
        HDR0: if (!tx_valid_q) begin
          tx_data_q  <= DATA_WIDTH'(len16[7:0]);
          tx_valid_q <= 1'b1;
          tx_last_q  <= (len_q == '0);
        end
`endif
        SEND: begin
          if (!tx_valid_q) begin
            tx_data_q  <= bus.send_data;
            tx_valid_q <= 1'b1;
            tx_last_q  <= is_last_idx;
          end else if (beat_acc && !tx_last_q) begin
            idx_q <= idx_q + IDX_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.send_next = (state == POP);
  assign bus.send_idx  = idx_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_last   = tx_last_q;
  assign pkt_done      = (state == DONE);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_xvc_packet_sender.sv
// Randomized self-checking bench for xvc_packet_sender: a packet-buffer responder and
// a transaction-level scoreboard (expected byte stream per popped packet).
module tb_xvc_packet_sender;
  localparam int DW = 8;
  localparam int LW = 16;
  localparam int IW = 16;
`ifdef TX_LEN_HEADER_EN
  localparam int HB = 2;
`else
  localparam int HB = 0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic pkt_done;
  logic busy;

  xvc_packet_sender_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .IDX_WIDTH(IW)) bus ();

  xvc_packet_sender #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .IDX_WIDTH(IW)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus.master),
    .pkt_done (pkt_done),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int         pend_len[$];
  logic [7:0] pend_dat[$];
  logic [7:0] cur_mem [0:511];
  logic [7:0] exp_dat[$];
  bit         exp_lst[$];
  bit         pkt_open;
  int         pop_cyc, pkt_nbeats, mon_len;
  int         n_pop = 0, n_done = 0, n_beat = 0;
  int         s_pop, s_done, s_beat;
  int         rdy_mode;
  bit         prev_vld, prev_acc, prev_lst, prev_snext, acc;
  logic [7:0] prev_dat, got_dat;
  bit         got_lst;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Buffer responder, TX sink and scoreboard, all evaluated mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      exp_dat.delete();
      exp_lst.delete();
      pkt_open   = 1'b0;
      prev_vld   = 1'b0;
      prev_acc   = 1'b0;
      prev_snext = 1'b0;
    end else begin
      if (prev_vld && !prev_acc) begin
        check("hold_vld", bus.tx_valid, 1);
        check("hold_dat", bus.tx_data, prev_dat);
        check("hold_lst", bus.tx_last, prev_lst);
      end
      if (bus.send_next) begin
        check("pop_pulse", prev_snext, 0);
        n_pop++;
        if (pend_len.size() == 0) begin
          check("pop_empty", 1, 0);
        end else begin
          mon_len = pend_len.pop_front();
          for (int i = 0; i < mon_len; i++) cur_mem[i] = pend_dat.pop_front();
          bus.send_len = 16'(mon_len);
`ifdef TX_LEN_HEADER_EN
          exp_dat.push_back(8'(mon_len >> 8)); exp_lst.push_back(1'b0);
          exp_dat.push_back(8'(mon_len));      exp_lst.push_back(mon_len == 0);
`endif
          for (int i = 0; i < mon_len; i++) begin
            exp_dat.push_back(cur_mem[i]);
            exp_lst.push_back(i == mon_len - 1);
          end
          pkt_open   = 1'b1;
          pop_cyc    = cyc;
          pkt_nbeats = mon_len + HB;
        end
      end
      prev_snext    = bus.send_next;
      bus.send_data = cur_mem[bus.send_idx[8:0]];
      if (pkt_done) begin
        n_done++;
        check("done_open", pkt_open, 1);
        check("done_early", exp_dat.size(), 0);
        if (pkt_nbeats == 0) check("empty_gap", cyc - pop_cyc, 2);
        pkt_open = 1'b0;
      end
      case (rdy_mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = ~bus.tx_ready;
        default: bus.tx_ready = ($urandom_range(0, 3) != 0);
      endcase
      acc = bus.tx_valid && bus.tx_ready;
      if (acc) begin
        n_beat++;
        if (exp_dat.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          got_dat = exp_dat.pop_front();
          got_lst = exp_lst.pop_front();
          check("beat_dat", bus.tx_data, got_dat);
          check("beat_lst", bus.tx_last, got_lst);
        end
      end
      prev_vld = bus.tx_valid;
      prev_acc = acc;
      prev_dat = bus.tx_data;
      prev_lst = bus.tx_last;
    end
    bus.send_avail = (pend_len.size() != 0);
  end

  task automatic push_pkt(input int len, input int base, input bit rnd);
    for (int i = 0; i < len; i++) pend_dat.push_back(rnd ? 8'($urandom) : 8'(base + i));
    pend_len.push_back(len);
  endtask

  task automatic snap();
    s_pop = n_pop; s_done = n_done; s_beat = n_beat;
  endtask

  task automatic deltas(input string tag, input int p, input int d, input int b);
    check({tag, "_pops"},  n_pop - s_pop, p);
    check({tag, "_dones"}, n_done - s_done, d);
    check({tag, "_beats"}, n_beat - s_beat, b);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((pend_len.size() != 0 || exp_dat.size() != 0 || pkt_open || busy) && n < budget) begin
      @(posedge clock);
      n++;
    end
    check(tag, (n < budget), 1);
    repeat (2) @(posedge clock);
  endtask

  initial begin
    int n;
    int tot;
    reset = 1'b0; enable = 1'b0; rdy_mode = 0;
    bus.send_avail = 1'b0; bus.send_len = '0; bus.send_data = '0; bus.tx_ready = 1'b0;
    for (int i = 0; i < 512; i++) cur_mem[i] = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("rst_send_next", bus.send_next, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_last", bus.tx_last, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_send_idx", bus.send_idx, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1; enable = 1'b1;
    repeat (2) @(posedge clock);

    // single packet, always ready
    snap(); push_pkt(8, 100, 0); drain("t1_drain", 2000); deltas("t1", 1, 1, 8 + HB);
    // back-to-back with send_avail held
    snap(); push_pkt(8, 100, 0); push_pkt(4, 200, 0);
    drain("t2_drain", 2000); deltas("t2", 2, 2, 12 + 2 * HB);
    // toggling backpressure
    rdy_mode = 1;
    snap(); push_pkt(8, 100, 0); drain("t3_drain", 2000); deltas("t3", 1, 1, 8 + HB);
    rdy_mode = 0;
    // empty packet
    snap(); push_pkt(0, 0, 0); drain("t4_drain", 2000); deltas("t4", 1, 1, HB);

    // reset in the middle of a packet
    snap(); push_pkt(8, 100, 0);
    n = 0;
    while (n_beat < s_beat + 3 && n < 500) begin @(negedge clock); n++; end
    check("t5_wait", (n < 500), 1);
    @(posedge clock); #1;
    reset = 1'b0; #1;
    check("t5_send_next", bus.send_next, 0);
    check("t5_tx_valid", bus.tx_valid, 0);
    check("t5_tx_last", bus.tx_last, 0);
    check("t5_send_idx", bus.send_idx, 0);
    check("t5_pkt_done", pkt_done, 0);
    check("t5_busy", busy, 0);
    repeat (3) @(posedge clock);
    reset = 1'b1;
    repeat (20) @(posedge clock);
    check("t5_idle", busy, 0);
    deltas("t5", 1, 0, 3);

    // enable low blocks new pops
    enable = 1'b0;
    snap(); push_pkt(4, 200, 0);
    repeat (20) @(posedge clock);
    check("t6_no_pop", n_pop - s_pop, 0);
    check("t6_no_busy", busy, 0);
    enable = 1'b1;
    drain("t6_drain", 2000); deltas("t6", 1, 1, 4 + HB);

    // enable dropped mid-packet: current packet finishes, the next one waits
    snap(); push_pkt(6, 10, 0); push_pkt(5, 50, 0);
    n = 0;
    while (!busy && n < 100) begin @(posedge clock); n++; end
    check("t7_start", (n < 100), 1);
    enable = 1'b0;
    repeat (150) @(posedge clock);
    check("t7_pops", n_pop - s_pop, 1);
    check("t7_dones", n_done - s_done, 1);
    check("t7_pending", pend_len.size(), 1);
    enable = 1'b1;
    drain("t7_drain", 2000); deltas("t7", 2, 2, 11 + 2 * HB);

    // long packet (non-zero high length byte), random backpressure
    rdy_mode = 2;
    snap(); push_pkt(260, 0, 1); drain("long_drain", 5000); deltas("long", 1, 1, 260 + HB);

    // random batches
    for (int k = 0; k < 6; k++) begin
      rdy_mode = $urandom_range(0, 2);
      snap();
      tot = 0;
      for (int j = 0; j < 5; j++) begin
        n = $urandom_range(0, 12);
        tot += n + HB;
        push_pkt(n, 0, 1);
      end
      drain("rnd_drain", 5000);
      deltas("rnd", 5, 5, tot);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
